// File: rtl/fetch_stage.sv
// IF stage: PC register driving imem plus the IF/ID pipeline register (optional FETCH_PERF_EN counters).
// Latency: instr_f sampled at edge N appears on instr_d after edge N; pc_f is the PC register output.
// Backpressure: stall_f holds PC, stall_d holds IF/ID; redirect beats stall_f, flush beats stall_d.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    logic [31:0] pc_reg_q, pc_reg_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    always_comb begin
        pc_plus4 = pc_reg_q + 32'd4;
        // Target low bits are dropped rather than trapping on misalignment.
        pc_next  = pc_src_e ? {pc_target_e[31:2], 2'b00} : pc_plus4;

        pc_reg_d = pc_reg_q;
        if (pc_src_e) begin
            pc_reg_d = pc_next;
        end else if (!stall_f) begin
            pc_reg_d = pc_plus4;
        end

        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        if (flush_d) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_vld_d   = 1'b0;
        end else if (!stall_d) begin
            ifid_instr_d = instr_f;
            ifid_pc_d    = pc_reg_q;
            ifid_pc4_d   = pc_plus4;
            ifid_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg_q     <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_vld_q   <= 1'b0;
        end else begin
            pc_reg_q     <= pc_reg_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
        end
    end

    assign pc_f       = pc_reg_q;
    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_vld_q;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Observation only: nothing here feeds back into the datapath.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!flush_d && !stall_d) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
        if (stall_f && !pc_src_e) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule
